// File: rtl/inst_decode_queue.sv
// RV32I/RV32E decode stage: DEPTH-entry FIFO feeding a registered decode output
// stage, with an empty-queue bypass and a synchronous pipeline flush.
module inst_decode_queue #(
    parameter int DEPTH      = 2,
    parameter bit RVE        = 1'b0,
    parameter bit ENABLE_CSR = 1'b1,
    parameter int PC_W       = 32
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_imm,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   out_regwrite,
    output logic                   out_exc,
    output logic [3:0]             out_exc_cause,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [31:0]     imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            exc;
        logic [3:0]      cause;
    } bundle_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    bundle_t       out_q, out_d;

    logic    push, load, pop, bypass, wr_en;
    entry_t  src;
    bundle_t dec;
    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill, use_rs1, use_rs2, use_rd, wr, is_ecall, is_ebreak;

    // in_ready depends only on occupancy so there is no path from out_ready.
    assign in_ready = resetb & ~flush & (count_q < CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign load     = ~out_valid_q | out_ready;
    assign pop      = load & (count_q != '0);
    assign bypass   = load & (count_q == '0) & push;
    assign wr_en    = push & ~bypass;

    always_comb begin
        src.pc   = in_pc;
        src.inst = in_inst;
        if (count_q != '0) src = mem_q[rd_ptr_q];
    end

    always_comb begin
        ins       = src.inst;
        f3        = ins[14:12];
        f7        = ins[31:25];
        ill       = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        wr        = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        dec       = '0;
        dec.pc    = src.pc;
        dec.inst  = ins;
        case (ins[6:0])
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; wr = 1'b1;
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.imm = {27'b0, ins[24:20]};
                    ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
                end else begin
                    dec.imm = {{20{ins[31]}}, ins[31:20]};
                end
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1;
                dec.imm = {{20{ins[31]}}, ins[31:20]};
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; wr = 1'b1;
                dec.imm = {{20{ins[31]}}, ins[31:20]};
                ill = (f3 != 3'b000);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                ill = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                ill = (f3[2:1] == 2'b01);
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1; wr = 1'b1;
                dec.imm = {ins[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rd = 1'b1; wr = 1'b1;
                dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    is_ecall  = (ins == 32'h0000_0073);
                    is_ebreak = (ins == 32'h0010_0073);
                    ill = !(is_ecall || is_ebreak || ins == 32'h3020_0073);
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else begin
                    // f3[2] selects the uimm forms, whose rs1 slot is not a register
                    use_rd = 1'b1; wr = 1'b1; use_rs1 = ~f3[2];
                    dec.imm = {{20{ins[31]}}, ins[31:20]};
                    ill = !ENABLE_CSR;
                end
            end
            default: ill = 1'b1;
        endcase
        dec.rs1 = use_rs1 ? ins[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? ins[24:20] : 5'd0;
        dec.rd  = use_rd  ? ins[11:7]  : 5'd0;
        if (RVE && ((use_rs1 && ins[19]) || (use_rs2 && ins[24]) || (use_rd && ins[11])))
            ill = 1'b1;
        dec.exc      = ill | is_ecall | is_ebreak;
        dec.regwrite = wr & ~dec.exc;
        dec.cause    = ill ? 4'd2 : is_ecall ? 4'd11 : is_ebreak ? 4'd3 : 4'd0;
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(wr_en) - CW'(pop);
            if (load) begin
                out_valid_d = pop | bypass;
                if (pop | bypass) out_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {in_pc, in_inst};
    end

    assign count         = count_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_inst      = out_q.inst;
    assign out_imm       = out_q.imm;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_regwrite  = out_q.regwrite;
    assign out_exc       = out_q.exc;
    assign out_exc_cause = out_q.cause;
endmodule

// File: tb/tb_inst_decode_queue.sv
// Bench for inst_decode_queue: two instances (RV32I+CSR and RV32E without CSR)
// share stimulus; a queue-based model predicts occupancy, ordering and decode.
module tb_inst_decode_queue;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    logic clk = 1'b0, resetb = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [PC_W-1:0] in_pc = '0;

    logic a_in_ready, a_out_valid, a_rw, a_exc, b_in_ready, b_out_valid, b_rw, b_exc;
    logic [31:0] a_pc, a_inst, a_imm, b_pc, b_inst, b_imm;
    logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [3:0] a_cause, b_cause;
    logic [1:0] a_count, b_count;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    inst_decode_queue #(.DEPTH(DEPTH), .RVE(1'b0), .ENABLE_CSR(1'b1), .PC_W(PC_W)) u_a (
        .clk(clk), .resetb(resetb), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_inst(a_inst), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_rd(a_rd), .out_regwrite(a_rw), .out_exc(a_exc), .out_exc_cause(a_cause), .count(a_count));

    inst_decode_queue #(.DEPTH(DEPTH), .RVE(1'b1), .ENABLE_CSR(1'b0), .PC_W(PC_W)) u_b (
        .clk(clk), .resetb(resetb), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_inst(b_inst), .out_imm(b_imm), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_rd(b_rd), .out_regwrite(b_rw), .out_exc(b_exc), .out_exc_cause(b_cause), .count(b_count));

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, exc;
        logic [3:0]  cause;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Architectural decode straight from the ISA rules.
    function automatic dec_t ref_dec(logic [31:0] i, bit rve, bit csr);
        dec_t d = '0;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        bit r1 = 0, r2 = 0, rd = 0, wr = 0, bad = 0, ec = 0, eb = 0;
        logic [31:0] imm_i = int'($signed(i[31:20]));
        case (i[6:0])
            7'h33: begin
                r1 = 1; r2 = 1; rd = 1; wr = 1;
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                r1 = 1; rd = 1; wr = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d.imm = 32'(i[24:20]);
                    bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
                end else d.imm = imm_i;
            end
            7'h03: begin r1 = 1; rd = 1; wr = 1; d.imm = imm_i; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
            7'h67: begin r1 = 1; rd = 1; wr = 1; d.imm = imm_i; bad = (f3 != 3'd0); end
            7'h23: begin r1 = 1; r2 = 1; d.imm = int'($signed({i[31:25], i[11:7]})); bad = (f3 >= 3'd3); end
            7'h63: begin
                r1 = 1; r2 = 1; bad = f3 inside {3'd2, 3'd3};
                d.imm = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin rd = 1; wr = 1; d.imm = i & 32'hFFFF_F000; end
            7'h6F: begin rd = 1; wr = 1; d.imm = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h73: begin
                if (i == 32'h0000_0073) ec = 1;
                else if (i == 32'h0010_0073) eb = 1;
                else if (i == 32'h3020_0073) bad = 0;
                else if (f3 == 3'd0 || f3 == 3'd4) bad = 1;
                else begin rd = 1; wr = 1; r1 = !f3[2]; d.imm = imm_i; bad = !csr; end
            end
            default: bad = 1;
        endcase
        if (r1) d.rs1 = i[19:15];
        if (r2) d.rs2 = i[24:20];
        if (rd) d.rd  = i[11:7];
        if (rve && (d.rs1 >= 16 || d.rs2 >= 16 || d.rd >= 16)) bad = 1;
        d.exc   = bad || ec || eb;
        d.rw    = wr && !d.exc;
        d.cause = bad ? 4'd2 : ec ? 4'd11 : eb ? 4'd3 : 4'd0;
        return d;
    endfunction

    ent_t mq[$];
    bit   mov = 0;
    ent_t mout = '0;

    // Advance the model by one clock using the inputs currently applied, then clock.
    task automatic tick();
        bit push, used;
        push = resetb && !flush && in_valid && (mq.size() < DEPTH);
        used = 0;
        if (!resetb) begin mq.delete(); mov = 0; mout = '0; end
        else if (flush) begin mq.delete(); mov = 0; end
        else begin
            if (!mov || out_ready) begin
                if (mq.size() > 0) begin mout = mq.pop_front(); mov = 1; end
                else if (push) begin mout = '{in_pc, in_inst}; mov = 1; used = 1; end
                else mov = 0;
            end
            if (push && !used) mq.push_back('{in_pc, in_inst});
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 12);
        case (k)
            0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h03;  3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;  5: r[6:0] = 7'h37;  6: r[6:0] = 7'h17;  7: r[6:0] = 7'h6F;
            8: r[6:0] = 7'h67;  9: r[6:0] = 7'h73;  default: ;
        endcase
        if (k < 10 && $urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
        if (k == 9 && $urandom_range(0, 2) == 0)
            case ($urandom_range(0, 2))
                0: r = 32'h0000_0073;  1: r = 32'h0010_0073;  default: r = 32'h3020_0073;
            endcase
        if (r[6:0] == 7'h0F) r[0] = 1'b0;
        return r;
    endfunction

    task automatic test_reset();
        resetb = 0; in_valid = 1; in_inst = 32'h0010_0093;
        tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        checks++; if ({a_imm, a_inst, a_pc} !== '0) begin failures++; $display("FAIL reset_data got=%h %h %h exp=0", a_imm, a_inst, a_pc); end
        in_valid = 0; resetb = 1; #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_bypass();
        out_ready = 1; in_valid = 1; in_inst = 32'hFFF0_0293; in_pc = 32'h100;
        tick(); in_valid = 0;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%b exp=1", a_out_valid); end
        checks++; if (a_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bypass_imm got=%h exp=ffffffff", a_imm); end
        checks++; if (a_rd !== 5'd5 || a_rw !== 1'b1) begin failures++; $display("FAIL bypass_rd_rw got=%0d/%b exp=5/1", a_rd, a_rw); end
        checks++; if (a_pc !== 32'h100 || a_count !== 2'd0) begin failures++; $display("FAIL bypass_pc_count got=%h/%0d exp=100/0", a_pc, a_count); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bypass_drain got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [4];
        logic acc4;
        ins[0] = 32'h0010_0093; ins[1] = 32'h0020_0113; ins[2] = 32'h0030_0193; ins[3] = 32'h0040_0213;
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_inst = ins[k]; in_pc = 32'h200 + 4 * k;
            acc4 = a_in_ready;
            tick();
        end
        in_valid = 0;
        checks++; if (acc4 !== 1'b0) begin failures++; $display("FAIL bp_push4_accepted got=%b exp=0", acc4); end
        checks++; if (a_inst !== ins[0] || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h exp=%h", a_inst, ins[0]); end
        checks++; if (a_count !== 2'd2 || a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0d/%b exp=2/0", a_count, a_in_ready); end
        out_ready = 1;
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++; if (a_inst !== ins[k] || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, a_inst, ins[k]); end
        end
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", a_out_valid, a_count); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin in_valid = 1; in_inst = 32'h0050_0293 + (k << 20); tick(); end
        checks++; if (a_count !== 2'd2 || a_out_valid !== 1'b1) begin failures++; $display("FAIL flush_setup got=%0d/%b exp=2/1", a_count, a_out_valid); end
        flush = 1; in_valid = 1; in_inst = 32'hDEAD_0037; #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", a_in_ready); end
        tick(); flush = 0; in_valid = 0;
        checks++; if (a_count !== 2'd0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0d/%b exp=0/0", a_count, a_out_valid); end
        out_ready = 1; tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", a_out_valid); end
        in_valid = 1; in_inst = 32'h0000_0537; tick(); in_valid = 0;
        checks++; if (a_inst !== 32'h0000_0537) begin failures++; $display("FAIL flush_next got=%h exp=00000537", a_inst); end
    endtask

    task automatic test_exceptions();
        out_ready = 1; in_valid = 1;
        in_inst = 32'h0000_0073; tick();
        checks++; if ({a_exc, a_cause, a_rw} !== {1'b1, 4'd11, 1'b0}) begin failures++; $display("FAIL ecall got=%b/%0d/%b exp=1/11/0", a_exc, a_cause, a_rw); end
        in_inst = 32'h0000_701B; tick();
        checks++; if ({a_exc, a_cause} !== {1'b1, 4'd2}) begin failures++; $display("FAIL bad_opcode got=%b/%0d exp=1/2", a_exc, a_cause); end
        in_inst = 32'h4010_1093; tick();
        checks++; if ({a_exc, a_cause, a_rw} !== {1'b1, 4'd2, 1'b0}) begin failures++; $display("FAIL slli_f7 got=%b/%0d/%b exp=1/2/0", a_exc, a_cause, a_rw); end
        in_inst = 32'h0010_0073; tick();
        checks++; if ({a_exc, a_cause} !== {1'b1, 4'd3}) begin failures++; $display("FAIL ebreak got=%b/%0d exp=1/3", a_exc, a_cause); end
        in_inst = 32'h3020_0073; tick();
        checks++; if ({a_exc, a_cause, a_rw, a_out_valid} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL mret got=%b/%0d/%b exp=0/0/0", a_exc, a_cause, a_rw); end
        in_inst = 32'h3000_90F3; tick();
        checks++; if ({a_exc, a_rw, a_rd, a_rs1, a_imm} !== {1'b0, 1'b1, 5'd1, 5'd1, 32'h300}) begin failures++; $display("FAIL csr_en got=%b/%b/%0d/%0d/%h exp=0/1/1/1/300", a_exc, a_rw, a_rd, a_rs1, a_imm); end
        checks++; if ({b_exc, b_cause, b_rw} !== {1'b1, 4'd2, 1'b0}) begin failures++; $display("FAIL csr_dis got=%b/%0d/%b exp=1/2/0", b_exc, b_cause, b_rw); end
        in_valid = 0; tick();
    endtask

    task automatic test_rve();
        out_ready = 1; in_valid = 1; in_inst = 32'h0020_8833; tick(); in_valid = 0;
        checks++; if ({b_exc, b_cause, b_rw} !== {1'b1, 4'd2, 1'b0}) begin failures++; $display("FAIL rve_x16 got=%b/%0d/%b exp=1/2/0", b_exc, b_cause, b_rw); end
        checks++; if ({a_exc, a_rd, a_rw} !== {1'b0, 5'd16, 1'b1}) begin failures++; $display("FAIL rvi_x16 got=%b/%0d/%b exp=0/16/1", a_exc, a_rd, a_rw); end
        tick();
    endtask

    task automatic test_random();
        dec_t ea, eb;
        logic exp_rdy;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_inst   = gen_inst();
            in_pc     = $urandom;
            #1;
            exp_rdy = !flush && (mq.size() < DEPTH);
            checks++; if (a_in_ready !== exp_rdy || b_in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b/%b exp=%b", c, a_in_ready, b_in_ready, exp_rdy); end
            tick();
            checks++; if (a_count !== 2'(mq.size()) || b_count !== 2'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", c, a_count, b_count, mq.size()); end
            checks++; if (a_out_valid !== mov || b_out_valid !== mov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", c, a_out_valid, b_out_valid, mov); end
            if (mov) begin
                ea = ref_dec(mout.inst, 0, 1);
                eb = ref_dec(mout.inst, 1, 0);
                checks++; if ({a_pc, a_inst} !== mout || {b_pc, b_inst} !== mout) begin failures++; $display("FAIL rnd_payload cyc=%0d got=%h/%h exp=%h/%h", c, a_pc, a_inst, mout.pc, mout.inst); end
                checks++; if ({a_imm, a_rs1, a_rs2, a_rd, a_rw, a_exc, a_cause} !== ea) begin failures++; $display("FAIL rnd_dec_rvi cyc=%0d inst=%h got=%h exp=%h", c, mout.inst, {a_imm, a_rs1, a_rs2, a_rd, a_rw, a_exc, a_cause}, ea); end
                checks++; if ({b_imm, b_rs1, b_rs2, b_rd, b_rw, b_exc, b_cause} !== eb) begin failures++; $display("FAIL rnd_dec_rve cyc=%0d inst=%h got=%h exp=%h", c, mout.inst, {b_imm, b_rs1, b_rs2, b_rd, b_rw, b_exc, b_cause}, eb); end
            end
        end
        flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_backpressure();
        test_flush();
        test_exceptions();
        test_rve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_decode_queue.md
Name: inst_decode_queue

Overview:
Buffered, parametrised RV32I/RV32E decode stage placed between fetch and execute. Accepts raw instructions and their PCs over a valid/ready handshake into a DEPTH-entry queue. It decodes the head entry (register fields, immediate, writeback, exception cause) into a registered output stage with its own valid/ready handshake. It supports a pipeline flush and has a one-cycle bypass when the queue is empty.

Parameters:
DEPTH, 2, queue entries; power of two, minimum 2
RVE, 0, 1 makes any used register index at 16 or above illegal (RV32E)
ENABLE_CSR, 1, 0 makes all CSR instructions (SYSTEM with funct3 != 000) illegal
PC_W, 32, PC width carried alongside each instruction

Ports:
clk  in  1  clock
resetb  in  1  synchronous active-low reset
flush  in  1  discard all queued and output-stage instructions
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept
in_inst  in  32  raw instruction
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes the bundle
out_pc  out  PC_W  PC of the bundle
out_inst  out  32  raw instruction of the bundle
out_imm  out  32  sign/zero-extended immediate
out_rs1, out_rs2, out_rd  out  5 each  register indices; 0 when the format does not use the field
out_regwrite  out  1  writeback required; forced 0 when out_exc=1
out_exc  out  1  instruction raises an exception
out_exc_cause  out  4  2 = illegal, 3 = breakpoint, 11 = ecall; 0 when out_exc=0
count  out  $clog2(DEPTH)+1  queue occupancy, excluding the output stage

Behaviour:
- Reset (resetb=0 at the clk edge): count=0, out_valid=0, all out_* data=0. in_ready=0 while resetb=0.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- in_ready = resetb & !flush & (count < DEPTH).
- Output stage loads when !out_valid | out_ready.
  - Source is the queue head if count > 0.
  - Otherwise, if an input transfer happens that cycle, the input bypasses the queue: latency is 1 cycle from the accepting edge to out_valid.
  - Otherwise out_valid goes to 0.
- Queued path latency is at least 2 cycles. Order is strictly FIFO; bypass is allowed only when count=0.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged.
- Push is blocked when count = DEPTH, even if the output stage pops that cycle. in_ready depends only on count, with no combinational path from out_ready.
- Pointers wrap modulo DEPTH.
- Flush (synchronous, highest priority after reset): next edge gives count=0 and out_valid=0. Any in_valid that cycle is dropped.
- Output data holds stable while out_valid & !out_ready.
- Decode is combinational on the selected source and registered into the output stage.
- Immediates:
  - I-type: sign-extended inst[31:20].
  - SLLI/SRLI/SRAI: zero-extended inst[24:20].
  - U, J, B, S: standard RV32 formats.
  - R-type: 0.
- rs/rd usage:
  - R: rs1, rs2, rd.
  - I: rs1, rd.
  - S and B: rs1, rs2.
  - U and J: rd.
  - CSR immediate forms: rd only.
- regwrite = 1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD and CSR forms, unless out_exc=1.
- Illegal (cause 2):
  - inst[1:0] != 11, or unsupported opcode.
  - BRANCH funct3 of 010 or 011.
  - LOAD funct3 of 011, 110 or 111.
  - STORE funct3 of 011 or above.
  - OP funct7 not 0000000 or 0100000, or 0100000 with funct3 other than 000 or 101.
  - Shift-immediate inst[31:25] not 0000000, or 0100000 used with SLLI.
  - JALR funct3 != 000.
  - SYSTEM funct3 = 100.
  - SYSTEM funct3 = 000 with an encoding other than ECALL, EBREAK or MRET.
  - CSR form with ENABLE_CSR=0.
  - RVE=1 and any used register index has bit 4 set.
- ECALL (0x00000073) gives cause 11. EBREAK (0x00100073) gives cause 3. MRET (0x30200073) is legal, with no regwrite and no exception.
- When an exception is raised, the bundle is still delivered: out_valid=1 and out_pc is valid.

Test Plan:
- Reset then idle: resetb=0 for 2 cycles → out_valid=0, count=0, in_ready=0; after release, in_ready=1.
- Bypass: count=0, out_ready=1, push ADDI x5,x0,-1 (0xFFF00293) at edge N → at N+1 out_valid=1, out_imm=0xFFFFFFFF, out_rd=5, out_regwrite=1.
- Backpressure, DEPTH=2: out_ready=0, push 4 instructions → output stage holds #1, count=2, in_ready=0, #4 not accepted. Then out_ready=1 → outputs appear in order #1, #2, #3 on consecutive cycles.
- Flush mid-stream: count=2, out_valid=1, flush with in_valid=1 → next cycle count=0, out_valid=0, flushed input not delivered.
- Exceptions: 0x00000073 → out_exc=1, cause=11, out_regwrite=0. 0x0000701B → cause 2. SLLI with inst[30]=1 (0x40101093) → cause 2.
- RVE=1: ADD x16,x1,x2 (0x00208833) → cause 2. With RVE=0, the same instruction is legal, out_rd=16.
